serial_bus_master: RTL and testbench
====================================

# serial_bus_master

Initiator end of the ABruTECH serial bus. Takes a single read or write request from a local core, requests the bus from the arbiter, and runs the frame on the single-wire bus: start, slave ID, address, acknowledge wait, then the data phase. It returns read data or a completion or error pulse. It is the counterpart of the bus slave; each bus master port instantiates one of these.

## Interface
- ADDRESS_WIDTH, 15, address bits sent MSB first
- DATA_WIDTH, 8, data bits per transfer
- SID_WIDTH, 3, slave ID bits
- TIMEOUT_CYCLES, 255, maximum cycles in any wait state before abort (≥ 4)
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req  in  1  one-cycle transaction request, sampled only in IDLE
- rd_wrt_in  in  1  1 = write, 0 = read (bus encoding)
- slave_id  in  SID_WIDTH  target slave
- addr  in  ADDRESS_WIDTH  target address
- wdata  in  DATA_WIDTH  write data
- bus_grant  in  1  arbiter grant
- bus_request  out  1  arbiter request
- bus_util  out  1  high while this master owns the bus
- rd_wrt  out  1  latched rd_wrt_in, valid while bus_util = 1, otherwise 0
- rdata  out  DATA_WIDTH  read data, held until the next read completes
- done  out  1  one-cycle success pulse
- error  out  1  one-cycle timeout pulse
- busy  out  1  high from the accepted req until the done or error cycle
- data_bus_serial  inout  1  serial bus; released (Z) reads as 1 (external pull-up)

## Operation
- Reset: state IDLE; bus_request, bus_util, rd_wrt, done, error, busy = 0; rdata = 0; bus = Z; timeout counter = 0.
- IDLE: on req, latch rd_wrt_in, slave_id, addr and wdata. Set busy = 1 and go to REQ_BUS. A req while busy is ignored.
- REQ_BUS: hold bus_request = 1 until bus_grant = 1. Then set bus_request = 0, bus_util = 1, and go to START. There is no timeout here.
- START: drive 0 for 2 cycles.
- TX_SID: drive slave_id MSB first, 1 bit per cycle.
- TX_ADDR: drive addr MSB first, ADDRESS_WIDTH cycles. Then release the bus (Z).
- WAIT_ACK: wait until 0 is sampled on two consecutive cycles. A single 0 followed by 1 resets the pair detector but not the timeout. On ack: write goes to TX_PRE, read goes to WAIT_RSTART.
- TX_PRE (write): drive 0 for 1 cycle, then 1 for 1 cycle (the 0→1 sync marker).
- TX_DATA: drive wdata MSB first, DATA_WIDTH cycles. Then release the bus.
- WAIT_WDONE: the slave signals completion by driving 0 then 1. The master detects sampled 0 followed by sampled 1 (tracking the previous sample), then goes to FINISH.
- WAIT_RSTART (read): wait for the first sampled 0 (start bit), then go to RX_DATA.
- RX_DATA: shift in DATA_WIDTH bits MSB first, one per cycle, beginning the cycle after the start bit. The shift register is copied to rdata on the last bit. Then go to FINISH.
- FINISH: done = 1 for 1 cycle; bus_util, rd_wrt, busy → 0; bus Z; return to IDLE.
- Timeout: the counter clears on entry to WAIT_ACK, WAIT_WDONE and WAIT_RSTART and increments every cycle in those states. At TIMEOUT_CYCLES it goes to ERR: error = 1 for 1 cycle, bus_util, rd_wrt, busy → 0, bus Z, IDLE. rdata is unchanged on error.
- bus_grant is ignored outside REQ_BUS; the arbiter does not pre-empt.
- Only this master drives the bus in START, TX_SID, TX_ADDR, TX_PRE and TX_DATA. In every other state the bus is Z.

## Timing
- Bus is driven from registered outputs: a bit decided in cycle n appears on the bus in cycle n+1. The bus is sampled on the posedge.
- req to bus_request: 1 cycle. bus_grant to first start bit on the bus: 1 cycle.
- Header length: 2 + SID_WIDTH + ADDRESS_WIDTH = 20 cycles with defaults.
- Write, minimum: header + ack (≥ 2) + 2 + DATA_WIDTH + done handshake (≥ 2) + 1 FINISH cycle.
- Read: rdata is valid in the same cycle as the done pulse and remains stable afterwards.
- done and error are mutually exclusive; each is exactly 1 cycle per accepted req.
- rstn asserted mid-frame: the bus goes Z and all outputs reset asynchronously. The latched request is discarded and no done or error pulse is produced.

## Test plan
- Write, slave_id = 3'b010, addr = 15'h1234, wdata = 8'hA5, grant after 3 cycles, ack after 4 cycles, done handshake after 10 cycles -> bus carries 00,010,001001000110100, released, then 01,10100101; exactly one done pulse; bus_util high only from the cycle after grant through FINISH.
- Read, addr = 15'h7FFF; slave acks, then after 5 cycles sends start 0 followed by 8'h3C -> rdata = 8'h3C with one done pulse; rd_wrt = 0 during the frame.
- No ack: bus stays released (1) -> one error pulse exactly TIMEOUT_CYCLES cycles after WAIT_ACK entry; busy and bus_util = 0; rdata unchanged.
- Ack glitch: slave drives 0,1, then 0,0 -> the first lone 0 is rejected; the transaction proceeds after the 0,0 pair.
- Second req while busy, with different addr -> ignored; only the first transaction appears on the bus; one done pulse.
- rstn pulsed low during TX_ADDR bit 7 -> bus Z immediately, all outputs at reset values, no done or error pulse; a new req after reset completes normally.

Source files
------------

// File: rtl/serial_bus_master_if.sv
// rtl/serial_bus_master_if.sv - core request/response and arbiter signals of the serial bus master
interface serial_bus_master_if #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 8,
  parameter int SID_WIDTH     = 3
);
  logic                     req;
  logic                     rd_wrt_in;
  logic [SID_WIDTH-1:0]     slave_id;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     bus_grant;
  logic                     bus_request;
  logic                     bus_util;
  logic                     rd_wrt;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     done;
  logic                     error;
  logic                     busy;

  modport master (
    input  req, rd_wrt_in, slave_id, addr, wdata, bus_grant,
    output bus_request, bus_util, rd_wrt, rdata, done, error, busy
  );

  modport slave (
    output req, rd_wrt_in, slave_id, addr, wdata, bus_grant,
    input  bus_request, bus_util, rd_wrt, rdata, done, error, busy
  );
endinterface

// File: rtl/serial_bus_master.sv
// rtl/serial_bus_master.sv - initiator of the single-wire serial bus: arbitration, header, ack, data phase
module serial_bus_master #(
  parameter int ADDRESS_WIDTH  = 15,
  parameter int DATA_WIDTH     = 8,
  parameter int SID_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  serial_bus_master_if.master  ctrl_if,
  inout  wire                  data_bus_serial_io
);
  localparam int MAXW = (ADDRESS_WIDTH > DATA_WIDTH) ?
                        ((ADDRESS_WIDTH > SID_WIDTH) ? ADDRESS_WIDTH : SID_WIDTH) :
                        ((DATA_WIDTH > SID_WIDTH) ? DATA_WIDTH : SID_WIDTH);
  localparam int CW = $clog2(MAXW + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_BUS, S_START, S_TX_SID, S_TX_ADDR, S_WAIT_ACK, S_TX_PRE,
    S_TX_DATA, S_WAIT_WDONE, S_WAIT_RSTART, S_RX_DATA, S_FINISH, S_ERR
  } state_t;

  state_t                   state_q, state_d;
  logic                     rw_q, rw_d;
  logic [SID_WIDTH-1:0]     sid_q, sid_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     prev_zero_q, prev_zero_d;
  logic                     oe_q, oe_d;
  logic                     out_q, out_d;
  logic                     bus_request_q, bus_request_d;
  logic                     bus_util_q, bus_util_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     busy_q, busy_d;
  logic                     bus_bit;
  logic                     tmo_hit;

  // state_q names the phase currently visible on the wire; oe_q/out_q hold that cycle's bit
  assign data_bus_serial_io = oe_q ? out_q : 1'bz;
  assign bus_bit            = data_bus_serial_io;
  assign tmo_hit            = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  assign ctrl_if.bus_request = bus_request_q;
  assign ctrl_if.bus_util    = bus_util_q;
  assign ctrl_if.rd_wrt      = bus_util_q & rw_q;
  assign ctrl_if.rdata       = rdata_q;
  assign ctrl_if.done        = done_q;
  assign ctrl_if.error       = error_q;
  assign ctrl_if.busy        = busy_q;

  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    sid_d         = sid_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    shift_d       = shift_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    prev_zero_d   = prev_zero_q;
    oe_d          = oe_q;
    out_d         = out_q;
    bus_request_d = bus_request_q;
    bus_util_d    = bus_util_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    busy_d        = busy_q;
    unique case (state_q)
      S_IDLE: if (ctrl_if.req) begin
        rw_d          = ctrl_if.rd_wrt_in;
        sid_d         = ctrl_if.slave_id;
        addr_d        = ctrl_if.addr;
        wdata_d       = ctrl_if.wdata;
        busy_d        = 1'b1;
        bus_request_d = 1'b1;
        state_d       = S_REQ_BUS;
      end
      S_REQ_BUS: if (ctrl_if.bus_grant) begin
        bus_request_d = 1'b0;
        bus_util_d    = 1'b1;
        oe_d          = 1'b1;
        out_d         = 1'b0;
        cnt_d         = '0;
        state_d       = S_START;
      end
      S_START: if (cnt_q == '0) begin
        cnt_d = CW'(1);
      end else begin
        out_d   = sid_q[SID_WIDTH-1];
        sid_d   = sid_q << 1;
        cnt_d   = '0;
        state_d = S_TX_SID;
      end
      S_TX_SID: if (cnt_q == CW'(SID_WIDTH - 1)) begin
        out_d   = addr_q[ADDRESS_WIDTH-1];
        addr_d  = addr_q << 1;
        cnt_d   = '0;
        state_d = S_TX_ADDR;
      end else begin
        out_d = sid_q[SID_WIDTH-1];
        sid_d = sid_q << 1;
        cnt_d = cnt_q + CW'(1);
      end
      S_TX_ADDR: if (cnt_q == CW'(ADDRESS_WIDTH - 1)) begin
        oe_d        = 1'b0;
        out_d       = 1'b1;
        tmo_d       = '0;
        prev_zero_d = 1'b0;
        state_d     = S_WAIT_ACK;
      end else begin
        out_d  = addr_q[ADDRESS_WIDTH-1];
        addr_d = addr_q << 1;
        cnt_d  = cnt_q + CW'(1);
      end
      S_WAIT_ACK: begin
        tmo_d       = tmo_q + TW'(1);
        prev_zero_d = ~bus_bit;
        if (!bus_bit && prev_zero_q) begin
          tmo_d = '0;
          if (rw_q) begin
            oe_d    = 1'b1;
            out_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_TX_PRE;
          end else begin
            state_d = S_WAIT_RSTART;
          end
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end
      end
      S_TX_PRE: if (cnt_q == '0) begin
        out_d = 1'b1;
        cnt_d = CW'(1);
      end else begin
        out_d   = wdata_q[DATA_WIDTH-1];
        wdata_d = wdata_q << 1;
        cnt_d   = '0;
        state_d = S_TX_DATA;
      end
      S_TX_DATA: if (cnt_q == CW'(DATA_WIDTH - 1)) begin
        oe_d        = 1'b0;
        out_d       = 1'b1;
        tmo_d       = '0;
        prev_zero_d = 1'b0;
        state_d     = S_WAIT_WDONE;
      end else begin
        out_d   = wdata_q[DATA_WIDTH-1];
        wdata_d = wdata_q << 1;
        cnt_d   = cnt_q + CW'(1);
      end
      S_WAIT_WDONE: begin
        tmo_d       = tmo_q + TW'(1);
        prev_zero_d = ~bus_bit;
        if (bus_bit && prev_zero_q) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end
      end
      S_WAIT_RSTART: begin
        tmo_d = tmo_q + TW'(1);
        if (!bus_bit) begin
          cnt_d   = '0;
          state_d = S_RX_DATA;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end
      end
      S_RX_DATA: begin
        shift_d = {shift_q[DATA_WIDTH-2:0], bus_bit};
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          rdata_d = {shift_q[DATA_WIDTH-2:0], bus_bit};
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FINISH, S_ERR: begin
        bus_util_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      rw_q          <= 1'b0;
      sid_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      shift_q       <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      prev_zero_q   <= 1'b0;
      oe_q          <= 1'b0;
      out_q         <= 1'b1;
      bus_request_q <= 1'b0;
      bus_util_q    <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rw_q          <= rw_d;
      sid_q         <= sid_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      shift_q       <= shift_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      prev_zero_q   <= prev_zero_d;
      oe_q          <= oe_d;
      out_q         <= out_d;
      bus_request_q <= bus_request_d;
      bus_util_q    <= bus_util_d;
      done_q        <= done_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
    end
  end
endmodule

// File: tb/tb_serial_bus_master.sv
// tb/tb_serial_bus_master.sv - scoreboard bench for serial_bus_master with a scripted bus slave
module tb_serial_bus_master;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  serial_bus_master_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW)) bif ();

  wire  bus_w;
  logic slv_oe = 1'b0;
  logic slv_val = 1'b1;
  pullup (bus_w);
  assign bus_w = slv_oe ? slv_val : 1'bz;

  serial_bus_master #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ctrl_if(bif),
    .data_bus_serial_io(bus_w)
  );

  int    checks = 0;
  int    errors = 0;
  string one = "1";
  string zero = "0";
  string slave_script = "";

  bit          exp_err_q[$];
  logic [7:0]  exp_rd_q[$];
  bit          exp_rw_q[$];
  string       exp_tr_q[$];

  function automatic string rep(string c, int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  function automatic string bits(logic [31:0] v, int n);
    string s = "";
    for (int i = n - 1; i >= 0; i--) s = {s, (v[i] ? "1" : "0")};
    return s;
  endfunction

  function automatic string hdr(logic [2:0] sid, logic [14:0] a);
    return {"00", bits(32'(sid), SW), bits(32'(a), AW)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic chk_str(string name, string act, string want);
    int diff = -1;
    int n = (act.len() < want.len()) ? act.len() : want.len();
    checks++;
    for (int i = 0; i < n; i++) if (diff < 0 && act[i] != want[i]) diff = i;
    if (diff < 0 && act.len() != want.len()) diff = n;
    if (diff >= 0) begin
      errors++;
      $display("FAIL %s len got=%0d want=%0d first_diff=%0d", name, act.len(), want.len(), diff);
    end
  endtask

  task automatic push(bit err, logic [7:0] rd, bit rw, string tr);
    exp_err_q.push_back(err);
    exp_rd_q.push_back(rd);
    exp_rw_q.push_back(rw);
    exp_tr_q.push_back(tr);
  endtask

  // Slave: plays slave_script one character per cycle, index 0 = first bus_util cycle
  initial begin
    int         k = 0;
    logic       util_d = 1'b0;
    logic [7:0] c;
    forever begin
      @(posedge clk);
      #1;
      if (bif.bus_util && !util_d) k = 0;
      else if (bif.bus_util) k++;
      util_d = bif.bus_util;
      c = (bif.bus_util && k < slave_script.len()) ? slave_script[k] : 8'h7a;
      if (c == 8'h30 || c == 8'h31) begin
        slv_oe  = 1'b1;
        slv_val = (c == 8'h31);
      end else begin
        slv_oe  = 1'b0;
        slv_val = 1'b1;
      end
    end
  end

  // Monitor: records the wire while bus_util is high and scores every done/error pulse
  initial begin
    string      cap = "";
    string      cap_rw = "";
    bit         e;
    bit         rw;
    logic [7:0] rd;
    string      tr;
    forever begin
      @(negedge clk);
      if (bif.bus_util) begin
        cap    = {cap, (bus_w ? one : zero)};
        cap_rw = {cap_rw, (bif.rd_wrt ? one : zero)};
      end
      if (bif.done || bif.error) begin
        if (exp_err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse done=%0b error=%0b want none", bif.done, bif.error);
        end else begin
          e  = exp_err_q.pop_front();
          rd = exp_rd_q.pop_front();
          rw = exp_rw_q.pop_front();
          tr = exp_tr_q.pop_front();
          chk("pulse_kind", 32'({bif.done, bif.error}), e ? 32'h1 : 32'h2);
          chk("rdata_at_pulse", 32'(bif.rdata), 32'(rd));
          chk("busy_at_pulse", 32'(bif.busy), 32'h1);
          chk_str("bus_trace", cap, tr);
          chk_str("rd_wrt_trace", cap_rw, rep(rw ? one : zero, tr.len()));
        end
        cap    = "";
        cap_rw = "";
      end
      if (!bif.bus_util) begin
        cap    = "";
        cap_rw = "";
      end
    end
  end

  task automatic issue(bit rw, logic [2:0] sid, logic [14:0] a, logic [7:0] wd);
    bif.req       = 1'b1;
    bif.rd_wrt_in = rw;
    bif.slave_id  = sid;
    bif.addr      = a;
    bif.wdata     = wd;
    @(posedge clk);
    #1;
    bif.req = 1'b0;
    chk("req_to_bus_request", 32'(bif.bus_request), 32'h1);
    chk("busy_after_req", 32'(bif.busy), 32'h1);
  endtask

  task automatic grant_after(int d);
    repeat (d) begin
      @(posedge clk);
      #1;
    end
    chk("no_util_before_grant", 32'(bif.bus_util), 32'h0);
    bif.bus_grant = 1'b1;
    @(posedge clk);
    #1;
    bif.bus_grant = 1'b0;
    chk("util_after_grant", 32'(bif.bus_util), 32'h1);
    chk("request_drop_on_grant", 32'(bif.bus_request), 32'h0);
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    while (bif.busy && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bif.busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle busy=1 want=0 after %0d cycles", lim);
    end
    chk("util_low_after_end", 32'(bif.bus_util), 32'h0);
    chk("rd_wrt_low_after_end", 32'(bif.rd_wrt), 32'h0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bif.req = 1'b0; bif.rd_wrt_in = 1'b0; bif.slave_id = '0;
    bif.addr = '0;  bif.wdata = '0;       bif.bus_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_request", 32'(bif.bus_request), 32'h0);
    chk("rst_bus_util", 32'(bif.bus_util), 32'h0);
    chk("rst_rd_wrt", 32'(bif.rd_wrt), 32'h0);
    chk("rst_done_error", 32'({bif.done, bif.error}), 32'h0);
    chk("rst_busy", 32'(bif.busy), 32'h0);
    chk("rst_rdata", 32'(bif.rdata), 32'h0);
    chk("rst_bus_released", 32'(bus_w), 32'h1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // write, ack after 4 cycles, done handshake after 10; a second req while busy is dropped
    slave_script = {rep("z", 24), "00", rep("z", 20), "0"};
    push(1'b0, 8'h00, 1'b1, {hdr(3'b010, 15'h1234), "1111", "00", "01", bits(32'hA5, 8),
                             rep("1", 10), "011"});
    issue(1'b1, 3'b010, 15'h1234, 8'hA5);
    bif.req = 1'b1; bif.rd_wrt_in = 1'b0; bif.addr = 15'h0555;
    @(posedge clk);
    #1;
    bif.req = 1'b0;
    grant_after(2);
    wait_idle(200);

    // read of 15'h7FFF returning 8'h3C
    slave_script = {rep("z", 22), "00", rep("z", 5), "0", bits(32'h3C, 8)};
    push(1'b0, 8'h3C, 1'b0, {hdr(3'b101, 15'h7FFF), "11", "00", rep("1", 5), "0",
                             bits(32'h3C, 8), "1"});
    issue(1'b0, 3'b101, 15'h7FFF, 8'h00);
    grant_after(0);
    wait_idle(200);
    chk("rdata_held_after_read", 32'(bif.rdata), 32'h3C);

    // no ack: error exactly TO cycles after WAIT_ACK entry, rdata kept
    slave_script = "";
    push(1'b1, 8'h3C, 1'b0, {hdr(3'b001, 15'h0100), rep("1", TO + 1)});
    issue(1'b0, 3'b001, 15'h0100, 8'h00);
    grant_after(1);
    wait_idle(TO + 100);
    chk("busy_after_error", 32'(bif.busy), 32'h0);
    chk("rdata_kept_on_error", 32'(bif.rdata), 32'h3C);

    // lone 0 rejected as ack, 0,0 pair accepted; immediate done handshake
    slave_script = {rep("z", 21), "0", "z", "00", rep("z", 10), "0"};
    push(1'b0, 8'h3C, 1'b1, {hdr(3'b111, 15'h0001), "10100", "01", bits(32'h5A, 8), "011"});
    issue(1'b1, 3'b111, 15'h0001, 8'h5A);
    grant_after(1);
    wait_idle(200);

    // reset during TX_ADDR bit 7: no pulse, everything back to reset values
    slave_script = "";
    issue(1'b1, 3'b010, 15'h1234, 8'hA5);
    grant_after(1);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    chk("addr_bit7_driven_low", 32'(bus_w), 32'h0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_bus_released", 32'(bus_w), 32'h1);
    chk("midrst_outputs", 32'({bif.bus_request, bif.bus_util, bif.rd_wrt,
                               bif.done, bif.error, bif.busy}), 32'h0);
    chk("midrst_rdata", 32'(bif.rdata), 32'h0);
    #2 rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_midrst", 32'(bif.busy), 32'h0);

    // a fresh read after the aborted frame completes normally
    slave_script = {rep("z", 23), "00", "zz", "0", bits(32'hC3, 8)};
    push(1'b0, 8'hC3, 1'b0, {hdr(3'b011, 15'h2AAA), "111", "00", "11", "0",
                             bits(32'hC3, 8), "1"});
    issue(1'b0, 3'b011, 15'h2AAA, 8'h00);
    grant_after(2);
    wait_idle(200);

    chk("scoreboard_empty", 32'(exp_err_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
